mvm_seq_ctrl: RTL and testbench
===============================

# mvm_seq_ctrl

Sequencing controller for the M×M single-MAC matrix-vector multiply datapath (mvm_12_1_16_1 configuration: M=12, 16-bit inputs, 32-bit results). It decodes the loadMatrix / loadVector / start command pulses into write strobes and addresses for the matrix and vector memories. It schedules the M·M multiply-accumulate operations and y-buffer writes, then streams the M results out behind a one-cycle done pulse. It contains no data storage; all memories, the MAC and data_out live in the datapath.

## Interface
- M, 12, matrix dimension (rows = columns = vector length)
- MAW, $clog2(M*M), matrix memory address width
- VAW, $clog2(M), vector / y-buffer address width

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- loadMatrix  in  1  command pulse: M·M matrix words follow on data_in, row-major
- loadVector  in  1  command pulse: M vector words follow
- start  in  1  command pulse: compute y = A·x
- m_we  out  1  matrix memory write enable
- m_addr  out  MAW  matrix memory address (write and read)
- v_we  out  1  vector memory write enable
- v_addr  out  VAW  vector memory address (write and read)
- acc_en  out  1  MAC accumulate enable
- acc_clr  out  1  with acc_en: acc ← product (first column of a row)
- y_we  out  1  y-buffer write of accumulator
- y_addr  out  VAW  y-buffer write row
- out_en  out  1  datapath loads data_out ← ybuf[out_addr]
- out_addr  out  VAW  y-buffer read row
- done  out  1  one-cycle pulse; results follow on data_out
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD_M, LOAD_V, COMPUTE, DRAIN, DONE_OUT.
- IDLE: all strobes 0. Commands are sampled only in IDLE. Priority if several are high: start > loadMatrix > loadVector. Commands in any other state are ignored.
- LOAD_M: k = 0..M·M−1, one per cycle. m_we=1, m_addr=k. The data_in word for index k is present in the same cycle. After k=M·M−1, return to IDLE.
- LOAD_V: j = 0..M−1. v_we=1, v_addr=j. Then return to IDLE.
- COMPUTE: row r and col c counters (no divider). Each cycle issues a read: m_addr=r·M+c, v_addr=c. Memory read latency is 1.
  - The acc_en stage is the issue delayed by 1 cycle. acc_clr=1 when the delayed c==0.
  - The y_we stage is the issue delayed by 2 cycles, when the delayed c==M−1. y_addr = delayed r.
- DRAIN: covers the 2 pipeline cycles after the last issue. acc_en and y_we still follow the delayed tags.
- DONE_OUT: M cycles, j = 0..M−1. out_en=1, out_addr=j. done=1 only at j=0. Then return to IDLE.
- Arithmetic and accumulate width (2×input) are owned by the datapath. The controller only guarantees the exact strobe sequence.
- Memory contents persist across commands and reset. start without a prior load uses whatever is stored.

## Timing
- Reset: next cycle state=IDLE, all counters and delay tags 0. Every output is 0, including done, busy and all addresses. Reset mid-load, mid-compute or mid-output aborts with no further strobes.
- Command sampled at edge E. The first active cycle is E+1; busy=1 from E+1.
- LOAD_M occupies M·M cycles (144), LOAD_V occupies M cycles (12). A new command is accepted in the first IDLE cycle after either.
- start in cycle S:
  - Issues run S+1..S+M·M.
  - acc_en runs S+2..S+M·M+1.
  - y_we for row r occurs at S+M·r+M+2.
  - done occurs at S+M·M+3 (S+147).
- Results: out_en in cycles D..D+M−1, where D is the done cycle. data_out holds y[j] during cycle D+1+j and holds the last value afterwards. The next command is accepted from D+M.
- There is no overlap between compute and load. The y-buffer is rewritten only by the next start.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0, busy=0; loadMatrix pulse -> m_we=1 for exactly 144 consecutive cycles, m_addr 0..143, then IDLE.
- loadVector pulse -> v_we for 12 cycles, v_addr 0..11; a start asserted during the load is ignored (no acc_en).
- Full run with A=identity, x=1..12 through the datapath -> done at S+147; data_out 1..12 on the following 12 cycles.
- A entries all 181, x all −181 -> every y = −393132; acc_clr high on 12 acc_en cycles (c=0); y_we exactly 12 times, rows 0..11.
- Reset asserted at cycle S+70 of a compute -> no y_we or done afterwards; a subsequent start with unchanged memories gives correct results.
- loadMatrix and loadVector both high in the same IDLE cycle -> LOAD_M taken, 144 m_we cycles, no v_we.

Source files
------------

// File: rtl/mvm_seq_ctrl_if.sv
// Command and strobe bundle between the matrix-vector sequencer and its datapath.
// master issues the command pulses; slave (the sequencer) drives the memory/MAC strobes.
interface mvm_seq_ctrl_if #(
    parameter int unsigned M = 12
);
    localparam int unsigned MAW = $clog2(M * M);
    localparam int unsigned VAW = $clog2(M);

    logic           loadMatrix;
    logic           loadVector;
    logic           start;
    logic           m_we;
    logic [MAW-1:0] m_addr;
    logic           v_we;
    logic [VAW-1:0] v_addr;
    logic           acc_en;
    logic           acc_clr;
    logic           y_we;
    logic [VAW-1:0] y_addr;
    logic           out_en;
    logic [VAW-1:0] out_addr;
    logic           done;
    logic           busy;

    modport master (
        output loadMatrix, loadVector, start,
        input  m_we, m_addr, v_we, v_addr, acc_en, acc_clr,
               y_we, y_addr, out_en, out_addr, done, busy
    );

    modport slave (
        input  loadMatrix, loadVector, start,
        output m_we, m_addr, v_we, v_addr, acc_en, acc_clr,
               y_we, y_addr, out_en, out_addr, done, busy
    );
endinterface

// File: rtl/mvm_seq_ctrl.sv
// Strobe sequencer for the MxM single-MAC matrix-vector multiply datapath.
// Loads matrix/vector memories, schedules M*M MACs with 1- and 2-cycle delayed tags, then streams results.
module mvm_seq_ctrl #(
    parameter int unsigned M = 12
) (
    input logic           clk,
    input logic           reset,
    mvm_seq_ctrl_if.slave bus
);
    localparam int unsigned MAW = $clog2(M * M);
    localparam int unsigned VAW = $clog2(M);
    localparam logic [MAW-1:0] LAST_K = MAW'(M * M - 1);
    localparam logic [VAW-1:0] LAST_J = VAW'(M - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_M, LOAD_V, COMPUTE, DRAIN, DONE_OUT
    } state_e;

    state_e         state_q;
    logic [MAW-1:0] m_addr_q;
    logic [VAW-1:0] v_addr_q;
    logic [VAW-1:0] r_q;
    logic           m_we_q;
    logic           v_we_q;
    logic           iss_q;
    logic           drain_q;
    logic           acc_en_q;
    logic           acc_clr_q;
    logic [VAW-1:0] acc_r_q;
    logic [VAW-1:0] acc_c_q;
    logic           y_we_q;
    logic [VAW-1:0] y_addr_q;
    logic           out_en_q;
    logic [VAW-1:0] out_addr_q;
    logic           done_q;
    logic           busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            m_addr_q   <= '0;
            v_addr_q   <= '0;
            r_q        <= '0;
            m_we_q     <= 1'b0;
            v_we_q     <= 1'b0;
            iss_q      <= 1'b0;
            drain_q    <= 1'b0;
            acc_en_q   <= 1'b0;
            acc_clr_q  <= 1'b0;
            acc_r_q    <= '0;
            acc_c_q    <= '0;
            y_we_q     <= 1'b0;
            y_addr_q   <= '0;
            out_en_q   <= 1'b0;
            out_addr_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Read issue -> accumulate (1 cycle later) -> y write (2 cycles later)
            acc_en_q  <= iss_q;
            acc_clr_q <= iss_q && (v_addr_q == '0);
            acc_r_q   <= r_q;
            acc_c_q   <= v_addr_q;
            y_we_q    <= acc_en_q && (acc_c_q == LAST_J);
            y_addr_q  <= acc_r_q;
            done_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q  <= COMPUTE;
                        iss_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        m_addr_q <= '0;
                        v_addr_q <= '0;
                        r_q      <= '0;
                    end else if (bus.loadMatrix) begin
                        state_q  <= LOAD_M;
                        m_we_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        m_addr_q <= '0;
                    end else if (bus.loadVector) begin
                        state_q  <= LOAD_V;
                        v_we_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        v_addr_q <= '0;
                    end
                end
                LOAD_M: begin
                    if (m_addr_q == LAST_K) begin
                        state_q  <= IDLE;
                        m_we_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        m_addr_q <= '0;
                    end else begin
                        m_addr_q <= m_addr_q + MAW'(1);
                    end
                end
                LOAD_V: begin
                    if (v_addr_q == LAST_J) begin
                        state_q  <= IDLE;
                        v_we_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        v_addr_q <= '0;
                    end else begin
                        v_addr_q <= v_addr_q + VAW'(1);
                    end
                end
                COMPUTE: begin
                    // Row-major order makes r*M+c a plain running index
                    if (m_addr_q == LAST_K) begin
                        state_q  <= DRAIN;
                        iss_q    <= 1'b0;
                        drain_q  <= 1'b0;
                        m_addr_q <= '0;
                        v_addr_q <= '0;
                        r_q      <= '0;
                    end else begin
                        m_addr_q <= m_addr_q + MAW'(1);
                        if (v_addr_q == LAST_J) begin
                            v_addr_q <= '0;
                            r_q      <= r_q + VAW'(1);
                        end else begin
                            v_addr_q <= v_addr_q + VAW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q) begin
                        state_q    <= DONE_OUT;
                        drain_q    <= 1'b0;
                        out_en_q   <= 1'b1;
                        out_addr_q <= '0;
                        done_q     <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                DONE_OUT: begin
                    if (out_addr_q == LAST_J) begin
                        state_q    <= IDLE;
                        out_en_q   <= 1'b0;
                        out_addr_q <= '0;
                        busy_q     <= 1'b0;
                    end else begin
                        out_addr_q <= out_addr_q + VAW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.v_we     = v_we_q;
    assign bus.v_addr   = v_addr_q;
    assign bus.acc_en   = acc_en_q;
    assign bus.acc_clr  = acc_clr_q;
    assign bus.y_we     = y_we_q;
    assign bus.y_addr   = y_addr_q;
    assign bus.out_en   = out_en_q;
    assign bus.out_addr = out_addr_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Bench for mvm_seq_ctrl: command table with per-cycle strobe checks, plus a small
// behavioural datapath (memories, MAC, y-buffer, data_out) driven by the strobes.
module tb_mvm_seq_ctrl;
    localparam int M  = 12;
    localparam int MM = M * M;
    localparam int S_LAST = MM + 3 + M - 1;  // last busy cycle after start (158)

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mvm_seq_ctrl_if #(.M(M)) bus();
    mvm_seq_ctrl #(.M(M)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Behavioural datapath
    logic signed [15:0] data_in;
    logic signed [15:0] mmem [256];
    logic signed [15:0] vmem [16];
    logic signed [15:0] mrd, vrd;
    logic signed [31:0] acc, data_out;
    logic signed [31:0] ybuf [16];
    logic signed [31:0] prod;
    assign prod = 32'(mrd) * 32'(vrd);

    always_ff @(posedge clk) begin
        if (bus.m_we) mmem[bus.m_addr] <= data_in;
        if (bus.v_we) vmem[bus.v_addr] <= data_in;
        mrd <= mmem[bus.m_addr];
        vrd <= vmem[bus.v_addr];
        if (bus.acc_en) acc <= bus.acc_clr ? prod : acc + prod;
        if (bus.y_we) ybuf[bus.y_addr] <= acc;
        if (bus.out_en) data_out <= ybuf[bus.out_addr];
    end

    typedef struct {
        logic lm, lv, st;
        int   kind;   // 0 matrix load, 1 vector load, 2 compute
        int   dsel;   // 0 identity / 1..12, 1 all 181 / all -181
        int   e_mwe, e_vwe, e_acc, e_clr, e_ywe, e_done, e_busy;
    } vec_t;

    vec_t tbl [7];
    int n_cmp = 0;
    int n_fail = 0;
    logic signed [15:0] mat_src [MM];
    logic signed [15:0] vec_src [M];
    int sm [MM];
    int sv [M];
    int y_exp [M];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_src(input int dsel);
        for (int i = 0; i < MM; i++)
            mat_src[i] = (dsel == 0) ? ((i / M == i % M) ? 16'sd1 : 16'sd0) : 16'sd181;
        for (int j = 0; j < M; j++)
            vec_src[j] = (dsel == 0) ? 16'(j + 1) : -16'sd181;
    endtask

    function automatic int outs_word();
        return int'({bus.m_we, bus.m_addr, bus.v_we, bus.v_addr, bus.acc_en, bus.acc_clr,
                     bus.y_we, bus.y_addr, bus.out_en, bus.out_addr, bus.done, bus.busy});
    endfunction

    task automatic run_row(input vec_t v, input int idx);
        int c_mwe, c_vwe, c_acc, c_clr, c_ywe, c_done, c_busy;
        int seq_err, data_err, first_bad, last;
        bit e_mwe, e_vwe, e_acc, e_clr, e_ywe, e_done, e_oen, e_busy;
        int e_maddr, e_vaddr, e_oaddr, e_yaddr;
        c_mwe = 0; c_vwe = 0; c_acc = 0; c_clr = 0; c_ywe = 0; c_done = 0; c_busy = 0;
        seq_err = 0; data_err = 0; first_bad = -1;
        last = (v.kind == 0) ? MM : (v.kind == 1) ? M : S_LAST;
        fill_src(v.dsel);
        for (int r = 0; r < M; r++) begin
            y_exp[r] = 0;
            for (int c = 0; c < M; c++) y_exp[r] += sm[r * M + c] * sv[c];
        end
        @(negedge clk);
        bus.loadMatrix = v.lm; bus.loadVector = v.lv; bus.start = v.st;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.loadMatrix = 1'b0; bus.loadVector = 1'b0; bus.start = 1'b0;
            end
            data_in = (v.kind == 0 && n <= MM) ? mat_src[n - 1] :
                      (v.kind == 1 && n <= M)  ? vec_src[n - 1] : 16'sd0;
            e_busy  = n <= last;
            e_mwe   = v.kind == 0 && n <= MM;
            e_vwe   = v.kind == 1 && n <= M;
            e_acc   = v.kind == 2 && n >= 2 && n <= MM + 1;
            e_clr   = e_acc && ((n - 2) % M == 0);
            e_ywe   = v.kind == 2 && n >= M + 2 && n <= MM + 2 && ((n - M - 2) % M == 0);
            e_yaddr = (n - M - 2) / M;
            e_done  = v.kind == 2 && n == MM + 3;
            e_oen   = v.kind == 2 && n >= MM + 3 && n <= S_LAST;
            e_oaddr = e_oen ? n - MM - 3 : 0;
            e_maddr = (v.kind != 1 && n <= MM) ? n - 1 : 0;
            e_vaddr = (v.kind == 1 && n <= M) ? n - 1 : (v.kind == 2 && n <= MM) ? (n - 1) % M : 0;
            c_mwe  += int'(bus.m_we);
            c_vwe  += int'(bus.v_we);
            c_acc  += int'(bus.acc_en);
            c_clr  += int'(bus.acc_clr);
            c_ywe  += int'(bus.y_we);
            c_done += int'(bus.done);
            c_busy += int'(bus.busy);
            if (bus.m_we != e_mwe || bus.v_we != e_vwe || bus.acc_en != e_acc ||
                bus.acc_clr != e_clr || bus.y_we != e_ywe || bus.done != e_done ||
                bus.out_en != e_oen || bus.busy != e_busy ||
                int'(bus.m_addr) != e_maddr || int'(bus.v_addr) != e_vaddr ||
                int'(bus.out_addr) != e_oaddr || (e_ywe && int'(bus.y_addr) != e_yaddr)) begin
                seq_err++;
                if (first_bad < 0) first_bad = n;
            end
            if (v.kind == 2 && n >= MM + 4 && n <= S_LAST + 1 &&
                int'(data_out) != y_exp[n - MM - 4])
                data_err++;
            if (!bus.busy) break;
        end
        if (v.kind == 0) for (int i = 0; i < MM; i++) sm[i] = int'(mat_src[i]);
        if (v.kind == 1) for (int j = 0; j < M; j++) sv[j] = int'(vec_src[j]);
        check($sformatf("row%0d m_we count", idx), c_mwe, v.e_mwe);
        check($sformatf("row%0d v_we count", idx), c_vwe, v.e_vwe);
        check($sformatf("row%0d acc_en count", idx), c_acc, v.e_acc);
        check($sformatf("row%0d acc_clr count", idx), c_clr, v.e_clr);
        check($sformatf("row%0d y_we count", idx), c_ywe, v.e_ywe);
        check($sformatf("row%0d done count", idx), c_done, v.e_done);
        check($sformatf("row%0d busy cycles", idx), c_busy, v.e_busy);
        check($sformatf("row%0d strobe sequence errors (first at cycle %0d)", idx, first_bad),
              seq_err, 0);
        if (v.kind == 2) check($sformatf("row%0d data_out errors", idx), data_err, 0);
    endtask

    initial begin
        int c_vwe, c_acc, c_busy, c_ywe_pre, c_ywe_post, c_done_post;
        bus.loadMatrix = 1'b0; bus.loadVector = 1'b0; bus.start = 1'b0;
        data_in = '0;
        for (int i = 0; i < MM; i++) sm[i] = 0;
        for (int j = 0; j < M; j++) sv[j] = 0;

        //           lm    lv    st   kind dsel mwe vwe acc  clr ywe done busy
        tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 0, MM, 0, 0,  0,  0,  0,  MM};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1, 0, 0,  M, 0,  0,  0,  0,  M};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 2, 0, 0,  0, MM, M,  M,  1,  S_LAST};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 0, 1, MM, 0, 0,  0,  0,  0,  MM};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 2, 1, 0,  0, MM, M,  M,  1,  S_LAST};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1, 1, 0,  M, 0,  0,  0,  0,  M};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 2, 1, 0,  0, MM, M,  M,  1,  S_LAST};

        // Reset, then five idle cycles with every output low
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle outputs cycle %0d", i), outs_word(), 0);
        end

        for (int i = 0; i < 7; i++) begin
            run_row(tbl[i], i);
            if (i == 2) check("identity y[11] held", int'(data_out), 12);
            if (i == 4) check("181 x (1..12) y[11] held", int'(data_out), 14118);
            if (i == 6) check("181 x -181 y[11] held", int'(data_out), -393132);
        end

        // start pulsed while LOAD_V is running must be ignored
        fill_src(1);
        c_vwe = 0; c_acc = 0; c_busy = 0;
        @(negedge clk);
        bus.loadVector = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            bus.loadVector = 1'b0;
            bus.start = (n == 5);
            data_in = (n <= M) ? vec_src[n - 1] : 16'sd0;
            c_vwe  += int'(bus.v_we);
            c_acc  += int'(bus.acc_en);
            c_busy += int'(bus.busy);
        end
        bus.start = 1'b0;
        check("ignored start: v_we count", c_vwe, M);
        check("ignored start: acc_en count", c_acc, 0);
        check("ignored start: busy cycles", c_busy, M);

        // Reset at S+70 of a compute aborts all further strobes
        c_ywe_pre = 0; c_ywe_post = 0; c_done_post = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (n <= 70) c_ywe_pre += int'(bus.y_we);
            else begin
                c_ywe_post  += int'(bus.y_we);
                c_done_post += int'(bus.done);
            end
            if (n == 71) check("outputs right after mid-compute reset", outs_word(), 0);
            reset = (n == 70);
        end
        reset = 1'b0;
        check("y_we before reset", c_ywe_pre, 5);
        check("y_we after reset", c_ywe_post, 0);
        check("done after reset", c_done_post, 0);

        run_row(tbl[6], 7);
        check("rerun after reset y[11] held", int'(data_out), -393132);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
